uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver. It captures each received word on the receiver's one-cycle ready pulse and stores it in a circular FIFO. Words are presented to the consumer through a first-word-fall-through valid/ready port. It drives the receiver's can-receive-next-word input, and records words dropped on overflow.

Parameters:
WIDTH, 8, data word width in bits; must match the receiver word width.
DEPTH, 16, number of FIFO entries; power of two, at least 2.
ALMOST_FULL, DEPTH-2, fill level at or above which almost_full asserts; range 1..DEPTH.

Ports:
clock  input  1  system clock; all logic on rising edge.
resetn  input  1  asynchronous, active-low reset.
rx_data  input  WIDTH  word from receiver; sampled only when rx_ready=1.
rx_ready  input  1  one-cycle pulse from receiver: rx_data holds a new word.
rx_can_receive  output  1  to receiver's can-receive-next-word input; equals !full.
out_data  output  WIDTH  head word; 0 when out_valid=0.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head word this cycle.
flush  input  1  synchronous clear of FIFO contents.
count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
almost_full  output  1  count >= ALMOST_FULL.
overrun  output  1  sticky: at least one word dropped since last clear.
overrun_clear  input  1  synchronous clear of overrun and drop_count.
drop_count  output  8  dropped words, saturating at 255.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Write pointer, read pointer and count are cleared to 0.
  - out_valid=0, out_data=0, rx_can_receive=1, almost_full=0, overrun=0, drop_count=0.
  - Memory contents are not reset.
- Storage: circular buffer of DEPTH entries.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
  - full = (count==DEPTH); empty = (count==0).
- Push: push = rx_ready && (!full || pop).
  - On push, mem[wr_ptr] <= rx_data and wr_ptr increments.
- Pop: pop = out_valid && out_ready.
  - On pop, rd_ptr increments.
  - out_ready while empty has no effect.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged when both or neither.
- Simultaneous push and pop when full: both succeed. The word is accepted, count stays at DEPTH, and no drop is recorded.
- Simultaneous push and pop when count=1: both succeed and count stays 1. The new word becomes head on the next cycle.
- Drop: rx_ready && full && !pop.
  - The word is discarded and no pointer changes.
  - overrun <= 1.
  - drop_count increments unless already 255.
- Latency and output timing:
  - A word pushed at edge N is visible on out_data/out_valid after edge N, i.e. one cycle.
  - There is no combinational bypass from rx_data to out_data.
  - out_data = mem[rd_ptr] combinationally when out_valid=1, else 0.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Flag derivation:
  - out_valid, rx_can_receive and almost_full derive from registered count only.
  - None of them depends combinationally on rx_ready or out_ready.
- flush (priority over push/pop in the same cycle):
  - Pointers and count are cleared to 0.
  - A same-cycle rx_ready word is discarded without counting as a drop.
  - A same-cycle pop is ignored.
  - overrun and drop_count are not affected.
- overrun_clear:
  - Clears overrun and drop_count to 0.
  - If a drop occurs in the same cycle, the drop wins: overrun=1, drop_count=1.
- flush and overrun_clear may be asserted together; each acts independently.

Test Plan:
- Reset, then push 0x41,0x42,0x43 with out_ready=0 -> count=3, out_valid=1, out_data=0x41. Then out_ready=1 for 3 cycles -> pops 0x41,0x42,0x43 in order; count=0; out_valid=0; out_data=0.
- Push 16 words 0x00..0x0F (DEPTH=16) -> almost_full asserts when count=14; rx_can_receive=0 at count=16. A 17th pulse with 0xAA and no pop -> dropped; overrun=1; drop_count=1; head stays 0x00.
- Full FIFO, rx_ready with 0x55 and out_ready=1 in the same cycle -> 0x00 popped, 0x55 stored at tail, count=16, overrun unchanged. Drain all 16 -> last word read is 0x55; pointers have wrapped.
- 300 rx_ready pulses while full with no pops -> drop_count=255 (saturated). Then overrun_clear -> overrun=0, drop_count=0. overrun_clear coincident with a drop -> overrun=1, drop_count=1.
- count=5, flush with rx_ready=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, rx_can_receive=1, drop_count unchanged. Next push 0x7E -> out_data=0x7E.
- Push 3 words, assert resetn=0 mid-cycle while out_ready=1 -> outputs immediately go to reset values without waiting for a clock edge. After release, the first push is read back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer sitting directly behind the UART receiver.
// It captures each word on the receiver's one-cycle rx_ready pulse into a
// circular FIFO. Words leave through a first-word-fall-through valid/ready
// port. It drives the receiver's can-receive input and counts dropped words.
//
// Ports:
//   clock, resetn          clock (rising edge); asynchronous active-low reset
//   rx_data, rx_ready      word from the receiver, valid for one cycle
//   rx_can_receive         !full, back to the receiver
//   out_data, out_valid    head word (0 when empty) and non-empty flag
//   out_ready              consumer takes the head word this cycle
//   flush                  synchronous clear of the FIFO contents
//   count, almost_full     fill level 0..DEPTH, and count >= ALMOST_FULL
//   overrun, drop_count    sticky drop flag, saturating drop counter
//   overrun_clear          synchronous clear of overrun and drop_count
module uart_rx_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = DEPTH - 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_ready,
    output logic                       rx_can_receive,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overrun,
    input  logic                       overrun_clear,
    output logic [7:0]                 drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic full, empty, push, pop, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // flush takes priority: it suppresses push, pop and drop in its cycle.
    // A push into a full FIFO is allowed when the head leaves the same cycle.
    assign pop  = !empty && out_ready && !flush;
    assign push = rx_ready && (!full || pop) && !flush;
    assign drop = rx_ready && full && !pop && !flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        drop_count_d = drop_count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // A drop in the same cycle as overrun_clear restarts the tally at 1.
        if (drop) begin
            overrun_d = 1'b1;
            if (overrun_clear)
                drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF)
                drop_count_d = drop_count_q + 8'd1;
        end else if (overrun_clear) begin
            overrun_d    = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    // All flags come from the registered count only.
    assign out_valid      = !empty;
    assign rx_can_receive = !full;
    assign almost_full    = (count_q >= CW'(ALMOST_FULL));
    assign out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count          = count_q;
    assign overrun        = overrun_q;
    assign drop_count     = drop_count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_ready = 1'b0;
    logic             rx_can_receive;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             flush = 1'b0;
    logic [4:0]       count;
    logic             almost_full;
    logic             overrun;
    logic             overrun_clear = 1'b0;
    logic [7:0]       drop_count;

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
        .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_can_receive(rx_can_receive), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .count(count), .almost_full(almost_full),
        .overrun(overrun), .overrun_clear(overrun_clear), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    // Reference model: FIFO contents as a queue, plus drop bookkeeping.
    logic [WIDTH-1:0] mq[$];
    // Scoreboard: words expected on the output port, popped by the monitor.
    logic [WIDTH-1:0] sb[$];
    bit               m_ov;
    int               m_drops;
    int               n_chk  = 0;
    int               n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = mq.size();
        chk("count", 32'(count), 32'(sz));
        chk("out_valid", 32'(out_valid), 32'(sz > 0));
        chk("out_data", 32'(out_data), (sz > 0) ? 32'(mq[0]) : 32'd0);
        chk("rx_can_receive", 32'(rx_can_receive), 32'(sz < DEPTH));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    // Monitor: every accepted head word must match the next scoreboard entry.
    always @(negedge clock) begin
        if (resetn && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) chk("pop_unexpected", 32'(out_data), 32'hDEAD);
            else                chk("pop_data", 32'(out_data), 32'(sb.pop_front()));
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit rxr, input logic [WIDTH-1:0] d, input bit ordy,
                         input bit fl, input bit oc);
        int sz;
        bit pop, push, drop;
        rx_ready = rxr; rx_data = d; out_ready = ordy; flush = fl; overrun_clear = oc;
        sz   = mq.size();
        pop  = (sz > 0) && ordy && !fl;
        push = rxr && !fl && ((sz < DEPTH) || pop);
        drop = rxr && !fl && (sz == DEPTH) && !pop;
        @(posedge clock);
        #1;
        if (fl) begin
            mq.delete();
            sb.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(d);
                sb.push_back(d);
            end
        end
        if (drop) begin
            m_ov = 1'b1;
            m_drops = oc ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (oc) begin
            m_ov = 1'b0;
            m_drops = 0;
        end
        rx_ready = 1'b0; out_ready = 1'b0; flush = 1'b0; overrun_clear = 1'b0;
        check_status();
    endtask

    initial begin
        m_ov = 1'b0;
        m_drops = 0;
        #2;
        check_status();
        @(posedge clock); #1;
        resetn = 1'b1;

        // Three words, then drain in order.
        cycle(1, 8'h41, 0, 0, 0);
        cycle(1, 8'h42, 0, 0, 0);
        cycle(1, 8'h43, 0, 0, 0);
        chk("head_41", 32'(out_data), 32'h41);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);
        chk("drained_data", 32'(out_data), 32'h0);

        // Fill to full, then one dropped word.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 8'(i), 0, 0, 0);
            if (i == AF - 1) chk("af_at_14", 32'(almost_full), 32'd1);
        end
        chk("can_rx_full", 32'(rx_can_receive), 32'd0);
        cycle(1, 8'hAA, 0, 0, 0);
        chk("drop_one", 32'(drop_count), 32'd1);
        chk("head_after_drop", 32'(out_data), 32'h00);

        // Push and pop together while full, then drain across the wrap.
        cycle(1, 8'h55, 1, 0, 0);
        chk("full_pushpop_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0, 0);

        // Saturating drop counter and overrun_clear interaction.
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 300; i++) cycle(1, 8'($urandom), 0, 0, 0);
        chk("drop_sat", 32'(drop_count), 32'd255);
        cycle(0, 8'h00, 0, 0, 1);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        cycle(1, 8'h99, 0, 0, 1);
        chk("clear_vs_drop", 32'(drop_count), 32'd1);

        // Flush at count=5 with coincident push and pop.
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0);
        cycle(1, 8'hEE, 1, 1, 0);
        chk("flush_count", 32'(count), 32'd0);
        cycle(1, 8'h7E, 0, 0, 0);
        chk("after_flush", 32'(out_data), 32'h7E);

        // Randomized traffic with shifting fill/drain bias.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                cycle(($urandom_range(0, 99) < ((ph % 2) ? 30 : 75)),
                      8'($urandom),
                      ($urandom_range(0, 99) < ((ph % 2) ? 80 : 35)),
                      ($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 31) == 0));
            end
        end

        // Asynchronous reset mid-cycle while popping.
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0);
        out_ready = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        mq.delete(); sb.delete(); m_ov = 1'b0; m_drops = 0;
        check_status();
        #2;
        resetn = 1'b1;
        out_ready = 1'b0;
        @(posedge clock); #1;
        check_status();
        cycle(1, 8'h5A, 0, 0, 0);
        chk("post_reset_head", 32'(out_data), 32'h5A);
        cycle(0, 8'h00, 1, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
